// File: rtl/instr_encoder.sv
// RV64 instruction encoder: turns LD/SD/ADDI/BEQ field sets into 32-bit words
// and streams them as sequential instruction-memory writes from word 0.
module instr_encoder #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    op_sel,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  input  logic [63:0]                   imm,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [31:0]                   wr_data,
  output logic                          full,
  output logic                          err,
  output logic [$clog2(IMEM_DEPTH):0]   count
);
  localparam int CW = $clog2(IMEM_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic        ok;
  } enc_t;

  state_t state, state_nxt;
  enc_t   enc;
  logic   xfer;
  logic   is_ok, b_ok;

  // Sign-extension checks: upper bits must all replicate the encoded sign bit.
  assign is_ok = (&imm[63:11]) | ~(|imm[63:11]);
  assign b_ok  = ((&imm[63:12]) | ~(|imm[63:12])) & ~imm[0];

  assign in_ready = (state == RUN) && !start;
  assign xfer     = in_valid && in_ready;
  assign full     = (state == FULL);

  always_comb begin
    enc = '0;
    case (op_sel)
      2'd0: begin
        enc.word = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
        enc.ok   = is_ok;
      end
      2'd1: begin
        enc.word = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
        enc.ok   = is_ok;
      end
      2'd2: begin
        enc.word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        enc.ok   = is_ok;
      end
      default: begin
        enc.word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        enc.ok   = b_ok;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = RUN;
    else if (xfer && enc.ok && (count == CW'(IMEM_DEPTH - 1)))
      state_nxt = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        count <= '0;
        err   <= 1'b0;
      end else if (xfer) begin
        if (enc.ok) begin
          wr_en   <= 1'b1;
          wr_data <= enc.word;
          wr_addr <= ADDR_W'({count, 2'b00});
          count   <= count + CW'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a field-level reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic        in_ready;
  logic [1:0]  op_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        full, err;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  // model: mode 0 idle, 1 loading, 2 memory full
  int          m_mode, m_cnt;
  logic        m_err, m_wen;
  logic [63:0] m_addr;
  logic [31:0] m_data;

  instr_encoder #(.IMEM_DEPTH(DEPTH), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [4:0] d,
                                           input logic [4:0] a, input logic [4:0] b,
                                           input logic [63:0] im);
    longint unsigned u = im;
    longint unsigned w;
    case (op)
      2'd0: w = ((u & 'hFFF) << 20) | (64'(a) << 15) | (64'd3 << 12) | (64'(d) << 7) | 64'd3;
      2'd1: w = (((u >> 5) & 'h7F) << 25) | (64'(b) << 20) | (64'(a) << 15) | (64'd3 << 12)
              | ((u & 'h1F) << 7) | 64'd35;
      2'd2: w = ((u & 'hFFF) << 20) | (64'(a) << 15) | (64'(d) << 7) | 64'd19;
      default: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (64'(b) << 20)
              | (64'(a) << 15) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 64'd99;
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_ok(input logic [1:0] op, input logic [63:0] im);
    longint s = im;
    if (op == 2'd3) return (s >= -4096) && (s <= 4095) && (im[0] == 1'b0);
    return (s >= -2048) && (s <= 2047);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_err = 0; m_wen = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_wen));
    chk({tag, ".addr"},  wr_addr, m_addr);
    chk({tag, ".data"},  64'(wr_data), 64'(m_data));
    chk({tag, ".count"}, 64'(count), 64'(m_cnt));
    chk({tag, ".err"},   64'(err), 64'(m_err));
    chk({tag, ".full"},  64'(full), 64'(m_mode == 2));
  endtask

  // One clock: present inputs, check in_ready, advance model and DUT, check outputs.
  task automatic step(input logic s, input logic v, input logic [1:0] op, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b, input logic [63:0] im,
                      input string tag);
    bit rdy;
    start = s; in_valid = v; op_sel = op; rd = d; rs1 = a; rs2 = b; imm = im;
    #1;
    rdy = rst_n && (m_mode == 1) && !s;
    chk({tag, ".ready"}, 64'(in_ready), 64'(rdy));
    if (!rst_n) model_reset();
    else begin
      m_wen = 0;
      if (s) begin
        m_mode = 1; m_cnt = 0; m_err = 0;
      end else if (v && rdy) begin
        if (ref_ok(op, im)) begin
          m_wen = 1; m_data = ref_word(op, d, a, b, im); m_addr = 64'(m_cnt * 4);
          m_cnt++;
          if (m_cnt == DEPTH) m_mode = 2;
        end else m_err = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, tag);
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, ".ready"}, 64'(in_ready), 64'd0);
  endtask

  function automatic logic [63:0] rand_imm();
    longint v;
    longint bnd[10] = '{2047, -2048, 2048, -2049, 4095, -4096, 4096, -4097, 3, -4};
    case ($urandom_range(0, 3))
      0, 1: v = longint'($urandom_range(0, 8191)) - 4096;
      2:    v = bnd[$urandom_range(0, 9)];
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; op_sel = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    model_reset();
    #3;
    check_outputs("reset");
    chk("reset.ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // valid while idle must not write
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd5, "idle_valid");

    // single ADDI
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, "start1");
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd5, "addi");
    chk("addi.const", 64'(wr_data), 64'h00500093);

    // back-to-back LD, SD, BEQ
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, "start2");
    step(1'b0, 1'b1, 2'd0, 5'd2, 5'd1, 5'd0, 64'd8, "ld");
    chk("ld.const", 64'(wr_data), 64'h0080B103);
    step(1'b0, 1'b1, 2'd1, 5'd0, 5'd1, 5'd2, 64'd16, "sd");
    chk("sd.const", 64'(wr_data), 64'h0020B823);
    chk("sd.addr_const", wr_addr, 64'd4);
    step(1'b0, 1'b1, 2'd3, 5'd0, 5'd1, 5'd2, -64'sd4, "beq");
    chk("beq.const", 64'(wr_data), 64'hFE208EE3);
    chk("beq.addr_const", wr_addr, 64'd8);

    // range errors then a good write
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, "start3");
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd2048, "addi_oor");
    step(1'b0, 1'b1, 2'd3, 5'd0, 5'd1, 5'd2, 64'd3, "beq_odd");
    chk("err.const", 64'(err), 64'd1);
    step(1'b0, 1'b1, 2'd2, 5'd3, 5'd4, 5'd0, 64'd7, "addi_after_err");
    chk("err.sticky", 64'(err), 64'd1);

    // fill memory, fifth ignored, restart
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, "start4");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 2'd2, 5'(i + 1), 5'd0, 5'd0, 64'(i), "fill");
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.count", 64'(count), 64'd4);
    chk("fill.last_addr", wr_addr, 64'd12);
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, "restart");
    step(1'b0, 1'b1, 2'd2, 5'd9, 5'd0, 5'd0, 64'd1, "after_restart");
    chk("after_restart.addr", wr_addr, 64'd0);

    // async reset with one write in flight and another transfer pending
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd2, "pre_rst");
    start = 0; in_valid = 1;
    async_reset("rst_mid");
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd2, "in_rst");
    rst_n = 1'b1;
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd2, "post_rst1");
    step(1'b0, 1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 64'd2, "post_rst2");

    // start coincident with valid after an error
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 64'd0, "start5");
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd4096, "oor5");
    step(1'b0, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd1, "ok5");
    step(1'b1, 1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 64'd1, "start_valid");
    chk("start_valid.count", 64'(count), 64'd0);
    chk("start_valid.err", 64'(err), 64'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
        rst_n = 1'b1;
      end
      step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), rand_imm(), "rnd");
    end
    idle("tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, meaning instruction-memory capacity in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning the width of the byte-address output.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle pulse that restarts loading at word 0.
REQ-006 SHALL have port in_valid  input  1  meaning a field set is presented.
REQ-007 SHALL have port in_ready  output  1  meaning the block can accept a field set this cycle.
REQ-008 SHALL have port op_sel  input  2  meaning the instruction: 0 LD, 1 SD, 2 ADDI, 3 BEQ.
REQ-009 SHALL have ports rd, rs1, rs2  input  5 each  meaning the register indices.
REQ-010 SHALL have port imm  input  64  meaning the signed immediate; for BEQ it is the byte offset.
REQ-011 SHALL have port wr_en  output  1  meaning an imem write strobe.
REQ-012 SHALL have port wr_addr  output  ADDR_W  meaning the byte address (word index x4).
REQ-013 SHALL have port wr_data  output  32  meaning the encoded instruction.
REQ-014 SHALL have port full  output  1  meaning IMEM_DEPTH words have been written.
REQ-015 SHALL have port err  output  1  meaning a sticky immediate-range error.
REQ-016 SHALL have port count  output  $clog2(IMEM_DEPTH)+1  meaning the number of words written since start or reset.

Function
REQ-017 SHALL implement states IDLE, RUN and FULL; reset enters IDLE.
REQ-018 SHALL make the following transitions: IDLE->RUN on start; RUN->FULL on the write that makes count==IMEM_DEPTH; RUN or FULL->RUN on start; otherwise hold.
REQ-019 SHALL drive in_ready=1 only in RUN and not in the start cycle; a transfer occurs when in_valid&&in_ready.
REQ-020 SHALL use these encodings: LD opcode 0000011, funct3 011; SD 0100011, 011; ADDI 0010011, 000; BEQ 1100011, 000.
REQ-021 SHALL encode I-type (LD, ADDI) as imm[11:0], rs1, funct3, rd, opcode; rs2 is ignored.
REQ-022 SHALL encode S-type (SD) as imm[11:5], rs2, rs1, funct3, imm[4:0], opcode; rd is ignored.
REQ-023 SHALL encode B-type (BEQ) as imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode; rd is ignored.
REQ-024 SHALL treat an I/S immediate as in range iff imm[63:11] are all equal.
REQ-025 SHALL treat a B immediate as in range iff imm[63:12] are all equal and imm[0]==0.
REQ-026 SHALL, for an in-range transfer in cycle N, assert wr_en for exactly one cycle in N+1 with wr_data encoded and wr_addr=4*(count before the write); count increments in N+1.
REQ-027 SHALL, for an out-of-range transfer, produce no write, leave count unchanged and set err in N+1; err holds until start or reset.
REQ-028 SHALL register wr_data and wr_addr and hold them between writes; only wr_en qualifies them.
REQ-029 SHALL accept back-to-back transfers with one write per cycle and no bubbles.
REQ-030 SHALL, when start and in_valid are both high, ignore the field set; start clears count and err and suppresses any write in the following cycle.
REQ-031 SHALL drive full=1 only in FULL; in FULL, in_ready=0 and further in_valid is ignored.
REQ-032 SHALL not wrap addresses; the last write goes to byte address 4*(IMEM_DEPTH-1).

Reset
REQ-033 SHALL, on rst_n low at any time, immediately drive state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, full 0, err 0 and count 0.
REQ-034 SHALL not complete a transfer pending at reset assertion and SHALL issue no write after reset release until a start and a new transfer.

Verification
REQ-035 SHALL cover: start, then ADDI rd=1 rs1=0 imm=5 -> wr_en next cycle, wr_addr 0, wr_data 0x00500093, count 1.
REQ-036 SHALL cover: back-to-back LD rd=2 rs1=1 imm=8; SD rs1=1 rs2=2 imm=16; BEQ rs1=1 rs2=2 imm=-4 -> writes 0x0080B103 @0, 0x0020B823 @4, 0xFE208EE3 @8 on consecutive cycles.
REQ-037 SHALL cover: ADDI imm=2048, then BEQ imm=3 -> no writes, err=1, count unchanged; a following valid ADDI still writes and err stays 1.
REQ-038 SHALL cover: IMEM_DEPTH=4, five transfers -> four writes @0..12, full=1 and in_ready=0, fifth ignored; start -> full=0, count=0, next write @0.
REQ-039 SHALL cover: rst_n asserted in the cycle after a transfer and mid-stream -> all outputs 0 at once and no write after release until start.
REQ-040 SHALL cover: start coincident with in_valid -> no write, count 0, err cleared.
